snn_pattern_sequencer: RTL and testbench
========================================

SNN_PATTERN_SEQUENCER -- requirements
Module: snn_pattern_sequencer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- NUM_PRES, 4, spike presentations per pattern; legal range 1..255.
- PERIOD, 2, cycles between successive input spikes; legal range 2..255.
- SETTLE_CYC, 8, quiet cycles after the last period during which output spikes are still counted; legal range 0..255.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pattern request valid.
- in_ready  out  1  sequencer can accept a pattern.
- in_pattern  in  2  bit0 is logical input 1; bit1 is logical input 2.
- cfg_we  in  1  configuration write strobe.
- cfg_w  in  3  weights w1..w3 (bit0 = w1).
- cfg_th1, cfg_th2, cfg_th3  in  8 each  neuron thresholds.
- w1, w2, w3  out  1 each  registered weights to the network.
- th1, th2, th3  out  8 each  registered thresholds to the network.
- p_in_1, n_in_1, p_in_2, n_in_2  out  1 each  input spike pulses to the network.
- p_out_3, n_out_3  in  1 each  network output spikes.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_class  out  1  1 when positive output spikes outnumber negative ones.
- res_tie  out  1  1 when the positive and negative counts are equal.
- res_pos_cnt, res_neg_cnt  out  8 each  output spike counts.
REQ-003 The block SHALL use one clock, clk; reset SHALL be rst, asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, SPIKE, SETTLE and REPORT.
REQ-005 in_ready SHALL equal (state==IDLE); a pattern is accepted on a rising edge with in_valid&&in_ready, which captures in_pattern, clears both counts and enters SPIKE.
REQ-006 In SPIKE, a phase counter SHALL run 0..PERIOD-1, and a presentation counter SHALL run 0..NUM_PRES-1.
REQ-007 The spike outputs SHALL follow these pulse rules:
- In SPIKE at phase 0, for k in {1,2}: p_in_k = pattern bit, n_in_k = inverted pattern bit, for exactly one cycle.
- All spike outputs SHALL be 0 otherwise.
- p_in_k and n_in_k SHALL never be high together.
REQ-008 The first pulse SHALL appear in the cycle after the accepting edge, and pulses SHALL repeat every PERIOD cycles, NUM_PRES times in total.
REQ-009 After phase PERIOD-1 of the last presentation, the FSM SHALL enter SETTLE for SETTLE_CYC cycles, or go directly to REPORT if SETTLE_CYC==0.
REQ-010 During SPIKE and SETTLE, each cycle with p_out_3=1 SHALL increment res_pos_cnt, and each cycle with n_out_3=1 SHALL increment res_neg_cnt.
- Simultaneous p_out_3 and n_out_3 SHALL increment both counts.
- Both counters SHALL saturate at 255.
- Output spikes in IDLE or REPORT SHALL be ignored.
REQ-011 In REPORT, res_valid SHALL be 1, and res_class = (pos>neg), res_tie = (pos==neg), with counts held stable until res_valid&&res_ready.
REQ-012 The completing edge of REPORT (res_valid&&res_ready) SHALL enter IDLE; a new pattern SHALL be accepted no earlier than the following edge.
REQ-013 res_valid SHALL rise exactly 1+NUM_PRES*PERIOD+SETTLE_CYC rising edges after the accepting edge; this is 17 at the default parameters.
REQ-014 cfg_we SHALL load w1..w3 and th1..th3 on the next edge only in IDLE; cfg_we in any other state SHALL be ignored.
REQ-015 in_valid outside IDLE SHALL have no effect; the captured pattern SHALL not change mid-sequence.
REQ-016 res_class, res_tie and both counts SHALL be 0 whenever res_valid is 0.

Reset
REQ-017 While rst=1, the block SHALL hold the following values immediately, regardless of clk:
- state IDLE.
- All spike outputs 0.
- res_valid, res_class, res_tie and both counts 0.
- w1..w3 = 1.
- th1 = 4, th2 = 4, th3 = 2.
REQ-018 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-019 Reset asserted mid-SPIKE SHALL abort the sequence without completing the current pulse or producing a result.

Structure
REQ-020 The shared package snn_seq_pkg SHALL hold:
- the state enum;
- DEF_W = 3'b111;
- DEF_TH1 = 4, DEF_TH2 = 4, DEF_TH3 = 2;
- CNT_W = 8 and CNT_MAX = 255.
REQ-021 The saturating counter with synchronous clear SHALL be the sub-module snn_spike_counter, instantiated twice (positive and negative counts).

Verification
REQ-022 Reset: assert rst mid-simulation -> all outputs at their REQ-017 values asynchronously; in_ready=1 after release.
REQ-023 Pattern 2'b00, defaults: n_in_1 and n_in_2 pulse at edges +1, +3, +5, +7 after accept; p_in_1 and p_in_2 never high; res_valid at +17.
REQ-024 Pattern 2'b11, bench drives p_out_3 for 3 cycles in SPIKE, 1 cycle in SETTLE, and 2 cycles in REPORT -> pos=4, neg=0, class=1, tie=0.
REQ-025 p_out_3 and n_out_3 both high for 2 cycles in SETTLE -> pos=2, neg=2, class=0, tie=1.
REQ-026 Backpressure: hold res_ready=0 for 5 cycles -> res_valid and counts held; in_ready=0; a second in_valid is not accepted until the cycle after the handshake.
REQ-027 Configuration gating:
- cfg_we with th1=9 during SPIKE -> th1 stays 4.
- The same write in IDLE -> th1=9 after one edge.

Source files
------------

// File: rtl/snn_seq_pkg.sv
// Shared types and constants for the spiking-network pattern sequencer.
package snn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPIKE  = 2'd1,
    SETTLE = 2'd2,
    REPORT = 2'd3
  } seq_state_e;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  localparam logic [2:0] DEF_W = 3'b111;
  localparam logic [CNT_W-1:0] DEF_TH1 = 8'd4;
  localparam logic [CNT_W-1:0] DEF_TH2 = 8'd4;
  localparam logic [CNT_W-1:0] DEF_TH3 = 8'd2;

endpackage

// File: rtl/snn_spike_counter.sv
// Saturating event counter with synchronous clear, used for output spike tallies.
module snn_spike_counter
  import snn_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; the count sticks at CNT_MAX instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/snn_pattern_sequencer.sv
// Presents a 2-bit pattern to a small spiking network as repeated input spikes,
// tallies the network's positive/negative output spikes and reports the class.
module snn_pattern_sequencer
  import snn_seq_pkg::*;
#(
  parameter int NUM_PRES   = 4,
  parameter int PERIOD     = 2,
  parameter int SETTLE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_pattern,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_w,
  input  logic [CNT_W-1:0] cfg_th1,
  input  logic [CNT_W-1:0] cfg_th2,
  input  logic [CNT_W-1:0] cfg_th3,
  output logic             w1,
  output logic             w2,
  output logic             w3,
  output logic [CNT_W-1:0] th1,
  output logic [CNT_W-1:0] th2,
  output logic [CNT_W-1:0] th3,
  output logic             p_in_1,
  output logic             n_in_1,
  output logic             p_in_2,
  output logic             n_in_2,
  input  logic             p_out_3,
  input  logic             n_out_3,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_class,
  output logic             res_tie,
  output logic [CNT_W-1:0] res_pos_cnt,
  output logic [CNT_W-1:0] res_neg_cnt
);

  localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PRES_LAST   = CNT_W'(NUM_PRES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] pres_q;
  logic [CNT_W-1:0] settle_q;
  logic [1:0]       pattern_q;
  logic [2:0]       w_q;
  logic [CNT_W-1:0] th1_q;
  logic [CNT_W-1:0] th2_q;
  logic [CNT_W-1:0] th3_q;
  logic [CNT_W-1:0] pos_cnt;
  logic [CNT_W-1:0] neg_cnt;

  logic accept;
  logic last_phase;
  logic last_pres;
  logic counting;
  logic spike_now;

  assign accept     = in_valid && (state_q == IDLE);
  assign last_phase = (phase_q == PHASE_LAST);
  assign last_pres  = (pres_q == PRES_LAST);
  assign counting   = (state_q == SPIKE) || (state_q == SETTLE);
  assign spike_now  = (state_q == SPIKE) && (phase_q == '0);

  // State register; reset drops straight back to IDLE, aborting any sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: spike train, optional quiet window, then hold the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SPIKE;
      end
      SPIKE: begin
        if (last_phase && last_pres) begin
          state_d = (SETTLE_CYC == 0) ? REPORT : SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = REPORT;
      end
      REPORT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase, presentation and settle timers plus the pattern captured at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= '0;
      pres_q    <= '0;
      settle_q  <= '0;
      pattern_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            phase_q   <= '0;
            pres_q    <= '0;
            settle_q  <= '0;
            pattern_q <= in_pattern;
          end
        end
        SPIKE: begin
          if (last_phase) begin
            phase_q <= '0;
            if (!last_pres) pres_q <= pres_q + 1'b1;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        SETTLE: begin
          settle_q <= settle_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Network configuration registers; writes only land while the sequencer is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q   <= DEF_W;
      th1_q <= DEF_TH1;
      th2_q <= DEF_TH2;
      th3_q <= DEF_TH3;
    end else if (cfg_we && (state_q == IDLE)) begin
      w_q   <= cfg_w;
      th1_q <= cfg_th1;
      th2_q <= cfg_th2;
      th3_q <= cfg_th3;
    end
  end

  snn_spike_counter u_pos_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (counting && p_out_3),
    .count (pos_cnt)
  );

  snn_spike_counter u_neg_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (counting && n_out_3),
    .count (neg_cnt)
  );

  assign in_ready = (state_q == IDLE);

  assign w1  = w_q[0];
  assign w2  = w_q[1];
  assign w3  = w_q[2];
  assign th1 = th1_q;
  assign th2 = th2_q;
  assign th3 = th3_q;

  assign p_in_1 = spike_now &&  pattern_q[0];
  assign n_in_1 = spike_now && !pattern_q[0];
  assign p_in_2 = spike_now &&  pattern_q[1];
  assign n_in_2 = spike_now && !pattern_q[1];

  assign res_valid   = (state_q == REPORT);
  assign res_pos_cnt = res_valid ? pos_cnt : '0;
  assign res_neg_cnt = res_valid ? neg_cnt : '0;
  assign res_class   = res_valid && (pos_cnt > neg_cnt);
  assign res_tie     = res_valid && (pos_cnt == neg_cnt);

endmodule

// File: tb/tb_snn_pattern_sequencer.sv
// Scoreboard bench for the pattern sequencer: a timing-level model predicts the
// spike train and result, a monitor compares every presented result.
module tb_snn_pattern_sequencer;

  localparam int NP  = 4;
  localparam int PER = 2;
  localparam int SET = 8;
  localparam int WIN = NP * PER + SET;
  localparam int LAT = 1 + WIN;

  localparam int NP_B  = 255;
  localparam int PER_B = 2;
  localparam int LAT_B = 1 + NP_B * PER_B;

  typedef struct {
    int pos;
    int neg;
    logic cls;
    logic tie;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [1:0] in_pattern;
  logic cfg_we;
  logic [2:0] cfg_w;
  logic [7:0] cfg_th1, cfg_th2, cfg_th3;
  logic w1, w2, w3;
  logic [7:0] th1, th2, th3;
  logic p_in_1, n_in_1, p_in_2, n_in_2;
  logic p_out_3, n_out_3;
  logic res_valid, res_ready, res_class, res_tie;
  logic [7:0] res_pos_cnt, res_neg_cnt;

  logic in_valid_b, in_ready_b, res_valid_b, res_ready_b, res_class_b, res_tie_b;
  logic w1_b, w2_b, w3_b, p_in_1_b, n_in_1_b, p_in_2_b, n_in_2_b;
  logic [7:0] th1_b, th2_b, th3_b, res_pos_cnt_b, res_neg_cnt_b;

  result_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  logic [2:0] exp_w;
  logic [7:0] exp_th1, exp_th2, exp_th3;

  always #5 clk = ~clk;

  snn_pattern_sequencer #(.NUM_PRES(NP), .PERIOD(PER), .SETTLE_CYC(SET)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pattern(in_pattern),
    .cfg_we(cfg_we), .cfg_w(cfg_w), .cfg_th1(cfg_th1), .cfg_th2(cfg_th2), .cfg_th3(cfg_th3),
    .w1(w1), .w2(w2), .w3(w3), .th1(th1), .th2(th2), .th3(th3),
    .p_in_1(p_in_1), .n_in_1(n_in_1), .p_in_2(p_in_2), .n_in_2(n_in_2),
    .p_out_3(p_out_3), .n_out_3(n_out_3), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_tie(res_tie), .res_pos_cnt(res_pos_cnt), .res_neg_cnt(res_neg_cnt)
  );

  // Long-train instance with no quiet window, used to push the counters into saturation.
  snn_pattern_sequencer #(.NUM_PRES(NP_B), .PERIOD(PER_B), .SETTLE_CYC(0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_pattern(2'b00),
    .cfg_we(1'b0), .cfg_w(3'b000), .cfg_th1(8'd0), .cfg_th2(8'd0), .cfg_th3(8'd0),
    .w1(w1_b), .w2(w2_b), .w3(w3_b), .th1(th1_b), .th2(th2_b), .th3(th3_b),
    .p_in_1(p_in_1_b), .n_in_1(n_in_1_b), .p_in_2(p_in_2_b), .n_in_2(n_in_2_b),
    .p_out_3(1'b1), .n_out_3(1'b0), .res_valid(res_valid_b), .res_ready(res_ready_b),
    .res_class(res_class_b), .res_tie(res_tie_b), .res_pos_cnt(res_pos_cnt_b), .res_neg_cnt(res_neg_cnt_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Network output spikes for cycle n after acceptance (directed modes 1/2, quiet 3, random otherwise).
  function automatic logic [1:0] outVal(input int mode, input int n);
    case (mode)
      1: return {1'b0, ((n >= 1 && n <= 3) || n == 10 || n == LAT || n == LAT + 1)};
      2: return (n == 11 || n == 12) ? 2'b11 : 2'b00;
      3: return 2'b00;
      default: return 2'($urandom_range(0, 3));
    endcase
  endfunction

  // Monitor: compare any presented result with the oldest prediction; idle results must be zero.
  always @(negedge clk) begin
    checkOutput("in1_exclusive", {31'd0, p_in_1 & n_in_1}, 32'd0);
    checkOutput("in2_exclusive", {31'd0, p_in_2 & n_in_2}, 32'd0);
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_result: got res_valid=1, expected no result pending");
      end else begin
        checkOutput("res_pos_cnt", res_pos_cnt, exp_q[0].pos);
        checkOutput("res_neg_cnt", res_neg_cnt, exp_q[0].neg);
        checkOutput("res_class", res_class, exp_q[0].cls);
        checkOutput("res_tie", res_tie, exp_q[0].tie);
        if (res_ready) void'(exp_q.pop_front());
      end
    end else begin
      checkOutput("idle_result_zero", {res_pos_cnt, res_neg_cnt, 6'd0, res_class, res_tie}, 32'd0);
    end
  end

  task automatic checkConfig(input string name);
    checkOutput({name, "_w"}, {w3, w2, w1}, exp_w);
    checkOutput({name, "_th1"}, th1, exp_th1);
    checkOutput({name, "_th2"}, th2, exp_th2);
    checkOutput({name, "_th3"}, th3, exp_th3);
  endtask

  task automatic doConfig(input logic [2:0] w, input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] t3);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_w = w; cfg_th1 = t1; cfg_th2 = t2; cfg_th3 = t3;
    exp_w = w; exp_th1 = t1; exp_th2 = t2; exp_th3 = t3;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    checkConfig("cfg_idle_write");
  endtask

  // One full pattern: accept, spike train, report with backpressure, handshake.
  // A nonzero abort_at asserts reset inside that cycle and abandons the sequence.
  task automatic applyStimulus(input logic [1:0] pat, input int bp, input int mode, input int abort_at);
    int waited = 0;
    int pos = 0;
    int neg = 0;
    int n;
    logic exp_pulse;
    result_t r;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_before_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_pattern = pat;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (n = 1; n <= LAT; n++) begin
      in_pattern = 2'($urandom);
      {n_out_3, p_out_3} = outVal(mode, n);
      if (n == 2) begin
        cfg_we = 1'b1; cfg_w = 3'($urandom); cfg_th1 = 8'd9;
        cfg_th2 = 8'($urandom); cfg_th3 = 8'($urandom);
      end else begin
        cfg_we = 1'b0;
      end
      if (n <= WIN) begin
        pos += int'(p_out_3);
        neg += int'(n_out_3);
      end
      if (n == WIN) begin
        r.pos = (pos > 255) ? 255 : pos;
        r.neg = (neg > 255) ? 255 : neg;
        r.cls = (r.pos > r.neg);
        r.tie = (r.pos == r.neg);
        exp_q.push_back(r);
      end
      if (n == abort_at) begin
        #2 rst = 1'b1;
        #1;
        exp_w = 3'b111; exp_th1 = 8'd4; exp_th2 = 8'd4; exp_th3 = 8'd2;
        checkOutput("rst_spikes", {p_in_1, n_in_1, p_in_2, n_in_2}, 4'b0000);
        checkOutput("rst_res", {res_valid, res_class, res_tie}, 3'b000);
        checkOutput("rst_cnts", {res_pos_cnt, res_neg_cnt}, 16'd0);
        checkConfig("rst");
        cfg_we = 1'b0;
        p_out_3 = 1'b0;
        n_out_3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_rst", in_ready, 1);
        return;
      end
      @(negedge clk);
      exp_pulse = (n <= NP * PER) && ((n - 1) % PER == 0);
      checkOutput("p_in_1", p_in_1, exp_pulse && pat[0]);
      checkOutput("n_in_1", n_in_1, exp_pulse && !pat[0]);
      checkOutput("p_in_2", p_in_2, exp_pulse && pat[1]);
      checkOutput("n_in_2", n_in_2, exp_pulse && !pat[1]);
      checkOutput("res_valid_timing", res_valid, n == LAT);
      @(posedge clk); #1;
    end
    for (int k = 0; k < bp; k++) begin
      {n_out_3, p_out_3} = outVal(mode, LAT + 1 + k);
      in_valid = 1'b1;
      in_pattern = 2'($urandom);
      @(negedge clk);
      checkOutput("bp_res_valid", res_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    p_out_3 = 1'b0;
    n_out_3 = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput("post_hs_res_valid", res_valid, 0);
    checkOutput("post_hs_in_ready", in_ready, 1);
    checkConfig("cfg_mid_seq_ignored");
  endtask

  // Long train with p_out_3 held high: counts must clamp at 255 and skip the quiet window.
  task automatic checkSaturation();
    int cyc = 0;
    @(posedge clk); #1;
    in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!res_valid_b && cyc < LAT_B + 50);
    checkOutput("sat_latency", cyc, LAT_B);
    checkOutput("sat_pos", res_pos_cnt_b, 255);
    checkOutput("sat_neg", res_neg_cnt_b, 0);
    checkOutput("sat_class_tie", {res_class_b, res_tie_b}, 2'b10);
    @(posedge clk); #1;
    res_ready_b = 1'b1;
    @(posedge clk); #1;
    res_ready_b = 1'b0;
    @(negedge clk);
    checkOutput("sat_done", {res_valid_b, in_ready_b}, 2'b01);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pattern = 2'b00; cfg_we = 1'b0; cfg_w = 3'b000;
    cfg_th1 = 8'd0; cfg_th2 = 8'd0; cfg_th3 = 8'd0;
    p_out_3 = 1'b0; n_out_3 = 1'b0; res_ready = 1'b0;
    in_valid_b = 1'b0; res_ready_b = 1'b0;
    exp_w = 3'b111; exp_th1 = 8'd4; exp_th2 = 8'd4; exp_th3 = 8'd2;
    #12;
    checkConfig("init_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("in_ready_first", in_ready, 1);

    applyStimulus(2'b00, 5, 0, 0);
    doConfig(3'b101, 8'd9, 8'd7, 8'd3);
    applyStimulus(2'b11, 2, 1, 0);
    applyStimulus(2'b01, 0, 2, 0);
    applyStimulus(2'b10, 1, 0, 3);
    applyStimulus(2'b10, 0, 3, 0);
    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 1) doConfig(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      applyStimulus(2'($urandom), $urandom_range(0, 4), 0, 0);
    end
    checkSaturation();

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
